uart_tx_unit: RTL and testbench
===============================

# uart_tx_unit

Serial transmitter for the TP2 UART datapath. Accepts a parallel byte and a one-cycle start strobe from the UART/ALU interface. Shifts the byte out LSB-first as an asynchronous frame: start bit, data, optional parity, stop. Bit timing is paced by the shared 16x oversampling baud tick, and a one-cycle done pulse is returned to the interface when the frame completes.

## Interface

Parameters
- N_BITS_DATA, 8, data bits per frame (supported range 5–9)
- SB_TICKS, 16, baud ticks spent in the stop state (16 = 1 stop bit, 24 = 1.5, 32 = 2)
- PARITY_EN, 0, 1 inserts a parity bit after the data bits
- PARITY_ODD, 0, parity sense when PARITY_EN=1 (0 even, 1 odd)

Ports
- clock  input  1  system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock
- s_tick_i  input  1  baud tick; one-clock pulse at 16x the bit rate
- tx_start_i  input  1  one-cycle request to send tx_data_i
- tx_data_i  input  N_BITS_DATA  byte to transmit; sampled only when a request is accepted
- tx_o  output  1  serial line; idles high
- tx_busy_o  output  1  high from request acceptance until frame completion
- tx_done_tick_o  output  1  one-cycle pulse at end of stop period

## Operation

- States: IDLE, START, DATA, PARITY, STOP.
- Registers:
  - state
  - tick counter, 4 bits for START/DATA/PARITY; wide enough for SB_TICKS-1 in STOP
  - bit counter, ceil(log2(N_BITS_DATA)) bits
  - shift register, N_BITS_DATA bits
  - parity accumulator
  - tx_o register
- IDLE: tx_o=1, busy=0.
  - If tx_start_i=1: latch tx_data_i into the shift register and clear the counters.
  - Load the parity accumulator with PARITY_ODD.
  - Go to START.
- START: tx_o=0.
  - Each s_tick_i increments the tick counter.
  - On the tick where the counter equals 15: clear it and go to DATA.
- DATA: tx_o = shift register bit 0.
  - On the tick where the counter equals 15:
    - XOR the outgoing bit into the parity accumulator.
    - Shift the register right by one and clear the tick counter.
    - If the bit counter equals N_BITS_DATA-1, go to PARITY (PARITY_EN=1) or STOP (PARITY_EN=0).
    - Otherwise increment the bit counter.
- PARITY: tx_o = parity accumulator.
  - After 16 ticks, go to STOP.
- STOP: tx_o=1.
  - On the tick where the counter equals SB_TICKS-1: assert tx_done_tick_o for that single cycle and return to IDLE.
- tx_start_i while not in IDLE is ignored; it is not queued and tx_data_i is not resampled.
- s_tick_i has no effect in IDLE. The tick counter advances only on cycles with s_tick_i=1.
- A change on tx_data_i after acceptance does not affect the frame in progress.
- Reset (reset=0), from any state including mid-frame:
  - state=IDLE, all counters 0, shift register 0.
  - tx_o=1, tx_busy_o=0, tx_done_tick_o=0.
  - The partial frame is abandoned; no done pulse is issued.

## Timing

- tx_o is registered; the line value reflects the state with one clock of latency. No combinational path runs from inputs to tx_o.
- Request accepted on edge E: tx_o=0 and tx_busy_o=1 from E+1.
- Each start, data and parity bit lasts exactly 16 s_tick_i pulses. The stop period lasts SB_TICKS pulses.
- Frame length in ticks: 16·(1 + N_BITS_DATA + PARITY_EN) + SB_TICKS.
  - Default (8N1): 160 ticks.
- tx_done_tick_o is high in the same cycle tx_busy_o drops (busy low from the edge after the last stop tick).
- Back-to-back frames: a new tx_start_i may be asserted in the cycle tx_done_tick_o is high.
  - It is accepted on the following edge, so the line stays high for at least one clock between frames.
- tx_start_i coinciding with the final stop tick is ignored, because the block is still in STOP.
- Simultaneous reset=0 and tx_start_i=1: reset wins; no frame starts.

## Test plan

- Reset: hold reset=0 for 3 cycles with tx_start_i=1 -> tx_o=1, tx_busy_o=0, tx_done_tick_o=0 throughout; no frame starts after release until a new request.
- 8N1 with s_tick_i=1 every clock, send 0x55 -> line holds 0 for 16 cycles, then bits 1,0,1,0,1,0,1,0 for 16 cycles each, then 1 for 16; done pulse at cycle 160 after acceptance; busy high exactly 160 cycles.
- Tick pacing: s_tick_i every 4th clock, send 0xA3 -> each bit spans 64 clocks; LSB-first sequence 1,1,0,0,0,1,0,1.
- Parity: PARITY_EN=1, PARITY_ODD=0, send 0x07 -> parity bit 1. PARITY_ODD=1 -> 0. Frame length 176 ticks.
- Request while busy: send 0x0F, pulse tx_start_i with data 0xF0 during DATA -> transmitted frame is 0x0F only, one done pulse; then a request issued in the done cycle sends 0xF0 starting one clock later.
- Mid-frame reset: drive reset=0 during DATA bit 3 -> tx_o=1 on the next edge, no done pulse; a subsequent 0x81 transmits a full, correct frame.

Source files
------------

// File: rtl/uart_tx_unit.sv
// uart_tx_unit: asynchronous serial transmitter. Sends start bit, LSB-first
// data, optional parity and stop period, each bit paced by a 16x baud tick.
module uart_tx_unit #(
   parameter int N_BITS_DATA = 8,
   parameter int SB_TICKS    = 16,
   parameter int PARITY_EN   = 0,
   parameter int PARITY_ODD  = 0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   s_tick_i,
   input  logic                   tx_start_i,
   input  logic [N_BITS_DATA-1:0] tx_data_i,
   output logic                   tx_o,
   output logic                   tx_busy_o,
   output logic                   tx_done_tick_o
);

   // Tick counter must reach 15 for normal bits and SB_TICKS-1 in the stop period.
   localparam int TICK_W = ($clog2(SB_TICKS) > 4) ? $clog2(SB_TICKS) : 4;
   localparam int BIT_W  = $clog2(N_BITS_DATA);

   localparam logic [TICK_W-1:0] BIT_TICK_LAST  = TICK_W'(15);
   localparam logic [TICK_W-1:0] STOP_TICK_LAST = TICK_W'(SB_TICKS - 1);
   localparam logic [BIT_W-1:0]  DATA_BIT_LAST  = BIT_W'(N_BITS_DATA - 1);
   localparam logic              PAR_INIT       = (PARITY_ODD != 0);
   localparam logic              PAR_ON         = (PARITY_EN != 0);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                 state_q,  state_d;
   logic [TICK_W-1:0]      tick_q,   tick_d;
   logic [BIT_W-1:0]       bit_q,    bit_d;
   logic [N_BITS_DATA-1:0] shift_q,  shift_d;
   logic                   par_q,    par_d;
   logic                   tx_q,     tx_d;
   logic                   busy_q,   busy_d;
   logic                   done_q,   done_d;

   // Next-state logic; line, busy and done are derived from the next state so
   // the registered outputs line up with the state they describe.
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (tx_start_i) begin
               shift_d = tx_data_i;
               tick_d  = '0;
               bit_d   = '0;
               par_d   = PAR_INIT;
               state_d = START;
            end
         end
         START: begin
            if (s_tick_i) begin
               if (tick_q == BIT_TICK_LAST) begin
                  tick_d  = '0;
                  state_d = DATA;
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end
         end
         DATA: begin
            if (s_tick_i) begin
               if (tick_q == BIT_TICK_LAST) begin
                  par_d   = par_q ^ shift_q[0];
                  shift_d = shift_q >> 1;
                  tick_d  = '0;
                  if (bit_q == DATA_BIT_LAST) begin
                     state_d = PAR_ON ? PARITY : STOP;
                  end else begin
                     bit_d = bit_q + BIT_W'(1);
                  end
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end
         end
         PARITY: begin
            if (s_tick_i) begin
               if (tick_q == BIT_TICK_LAST) begin
                  tick_d  = '0;
                  state_d = STOP;
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end
         end
         STOP: begin
            if (s_tick_i) begin
               if (tick_q == STOP_TICK_LAST) begin
                  tick_d  = '0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PARITY:  tx_d = par_d;
         default: tx_d = 1'b1;
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers with synchronous active-low reset; a reset
   // abandons any frame in progress without a done pulse.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign tx_o           = tx_q;
   assign tx_busy_o      = busy_q;
   assign tx_done_tick_o = done_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// tb_uart_tx_unit: self-checking bench for uart_tx_unit. Four instances share
// stimulus: 8N1, 8E1, 8O1 and 8N1.5 (SB_TICKS=24). Each frame seen on the line,
// sampled once per baud tick, is compared against a tick-level frame model.
`timescale 1ns/1ps
module tb_uart_tx_unit;

   localparam int NDUT = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       s_tick;
   logic       tx_start;
   logic [7:0] tx_data;
   logic [3:0] tx_w, busy_w, done_w;

   int checks   = 0;
   int failures = 0;

   int cfg_pen  [NDUT] = '{0, 1, 1, 0};
   int cfg_podd [NDUT] = '{0, 0, 1, 0};
   int cfg_sb   [NDUT] = '{16, 16, 16, 24};

   bit line_a   [NDUT][256];
   bit exp_a    [NDUT][256];
   int exp_len  [NDUT];
   int ticks_n  [NDUT];
   int busy_cyc [NDUT];
   int done_cnt [NDUT];
   int done_at  [NDUT];
   bit timed_out;

   always #5 clk = ~clk;

   uart_tx_unit #(.N_BITS_DATA(8), .SB_TICKS(16), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
      .clock(clk), .reset(rst_n), .s_tick_i(s_tick), .tx_start_i(tx_start), .tx_data_i(tx_data),
      .tx_o(tx_w[0]), .tx_busy_o(busy_w[0]), .tx_done_tick_o(done_w[0]));
   uart_tx_unit #(.N_BITS_DATA(8), .SB_TICKS(16), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
      .clock(clk), .reset(rst_n), .s_tick_i(s_tick), .tx_start_i(tx_start), .tx_data_i(tx_data),
      .tx_o(tx_w[1]), .tx_busy_o(busy_w[1]), .tx_done_tick_o(done_w[1]));
   uart_tx_unit #(.N_BITS_DATA(8), .SB_TICKS(16), .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
      .clock(clk), .reset(rst_n), .s_tick_i(s_tick), .tx_start_i(tx_start), .tx_data_i(tx_data),
      .tx_o(tx_w[2]), .tx_busy_o(busy_w[2]), .tx_done_tick_o(done_w[2]));
   uart_tx_unit #(.N_BITS_DATA(8), .SB_TICKS(24), .PARITY_EN(0), .PARITY_ODD(0)) u_dut3 (
      .clock(clk), .reset(rst_n), .s_tick_i(s_tick), .tx_start_i(tx_start), .tx_data_i(tx_data),
      .tx_o(tx_w[3]), .tx_busy_o(busy_w[3]), .tx_done_tick_o(done_w[3]));

   // Frame model: list of bit values, each held 16 ticks, followed by the stop period.
   task automatic build_model(input logic [7:0] d);
      for (int i = 0; i < NDUT; i++) begin
         bit seq [$];
         int n;
         bit p;
         seq.push_back(1'b0);
         for (int b = 0; b < 8; b++) seq.push_back(d[b]);
         if (cfg_pen[i] != 0) begin
            p = (cfg_podd[i] != 0) ^ (^d);
            seq.push_back(p);
         end
         n = 0;
         foreach (seq[s]) begin
            for (int r = 0; r < 16; r++) begin
               exp_a[i][n] = seq[s];
               n++;
            end
         end
         for (int r = 0; r < cfg_sb[i]; r++) begin
            exp_a[i][n] = 1'b1;
            n++;
         end
         exp_len[i] = n;
      end
   endtask

   task automatic start_frame(input logic [7:0] d);
      tx_data  = d;
      tx_start = 1'b1;
      s_tick   = 1'b0;
      @(posedge clk); #1;
      tx_start = 1'b0;
   endtask

   // Drives baud ticks after an accepted request and records the line value
   // during every tick each busy instance consumes.
   task automatic capture(input int period, input bit rnd, input int inj_k,
                          input logic [7:0] inj_d, input bit stop_on_done0, input int max_cyc);
      bit t;
      int k;
      int tail;
      for (int i = 0; i < NDUT; i++) begin
         ticks_n[i] = 0; busy_cyc[i] = 0; done_cnt[i] = 0; done_at[i] = -1;
      end
      timed_out = 1'b0;
      k = 0;
      tail = 0;
      forever begin
         for (int i = 0; i < NDUT; i++) if (busy_w[i]) busy_cyc[i]++;
         t = rnd ? ($urandom_range(0, 1) == 1) : ((k % period) == period - 1);
         for (int i = 0; i < NDUT; i++) begin
            if (busy_w[i] && t) begin
               if (ticks_n[i] < 256) line_a[i][ticks_n[i]] = tx_w[i];
               ticks_n[i]++;
            end
         end
         s_tick   = t;
         tx_start = (k == inj_k);
         if (k == inj_k) tx_data = inj_d;
         else if (inj_k >= 0 && k > inj_k) tx_data = 8'($urandom);
         @(posedge clk); #1;
         tx_start = 1'b0;
         for (int i = 0; i < NDUT; i++) begin
            if (done_w[i]) begin
               done_cnt[i]++;
               done_at[i] = ticks_n[i];
            end
         end
         k++;
         if (stop_on_done0 && done_w[0]) break;
         if (busy_w == 4'b0000) tail++;
         else tail = 0;
         if (tail == 3) break;
         if (k >= max_cyc) begin
            timed_out = 1'b1;
            break;
         end
      end
      s_tick = 1'b0;
   endtask

   task automatic test_reset();
      int bad;
      rst_n = 1'b0; tx_start = 1'b1; s_tick = 1'b1; tx_data = 8'hA5;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         checks++;
         if (tx_w !== 4'hF || busy_w !== 4'h0 || done_w !== 4'h0) begin
            failures++;
            $display("FAIL reset_hold cyc%0d: tx=%b busy=%b done=%b required tx=1111 busy=0000 done=0000",
                     c, tx_w, busy_w, done_w);
         end
      end
      tx_start = 1'b0;
      rst_n = 1'b1;
      bad = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (tx_w !== 4'hF || busy_w !== 4'h0 || done_w !== 4'h0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL reset_release_idle: bad_cycles=%0d required=0", bad);
      end
   endtask

   task automatic test_8n1();
      int mism;
      start_frame(8'h55);
      checks++;
      if (tx_w !== 4'h0 || busy_w !== 4'hF) begin
         failures++;
         $display("FAIL accept_latency: tx=%b busy=%b required tx=0000 busy=1111", tx_w, busy_w);
      end
      build_model(8'h55);
      capture(1, 1'b0, -1, 8'h00, 1'b0, 2000);
      checks++;
      if (timed_out) begin failures++; $display("FAIL 8n1_timeout: timed_out=1 required=0"); end
      for (int i = 0; i < NDUT; i++) begin
         mism = 0;
         for (int k = 0; k < exp_len[i]; k++) if (line_a[i][k] !== exp_a[i][k]) mism++;
         checks++;
         if (mism != 0 || ticks_n[i] != exp_len[i]) begin
            failures++;
            $display("FAIL 8n1_frame dut%0d: bad_ticks=%0d ticks=%0d required bad=0 ticks=%0d",
                     i, mism, ticks_n[i], exp_len[i]);
         end
         checks++;
         if (done_cnt[i] != 1 || done_at[i] != exp_len[i] || busy_cyc[i] != exp_len[i]) begin
            failures++;
            $display("FAIL 8n1_timing dut%0d: done_cnt=%0d done_at=%0d busy=%0d required 1/%0d/%0d",
                     i, done_cnt[i], done_at[i], busy_cyc[i], exp_len[i], exp_len[i]);
         end
      end
   endtask

   task automatic test_tick_pacing();
      int mism;
      start_frame(8'hA3);
      build_model(8'hA3);
      capture(4, 1'b0, -1, 8'h00, 1'b0, 4000);
      checks++;
      if (timed_out) begin failures++; $display("FAIL pacing_timeout: timed_out=1 required=0"); end
      for (int i = 0; i < NDUT; i++) begin
         mism = 0;
         for (int k = 0; k < exp_len[i]; k++) if (line_a[i][k] !== exp_a[i][k]) mism++;
         checks++;
         if (mism != 0 || ticks_n[i] != exp_len[i] || done_cnt[i] != 1 || busy_cyc[i] != 4 * exp_len[i]) begin
            failures++;
            $display("FAIL pacing dut%0d: bad=%0d ticks=%0d done=%0d busy=%0d required 0/%0d/1/%0d",
                     i, mism, ticks_n[i], done_cnt[i], busy_cyc[i], exp_len[i], 4 * exp_len[i]);
         end
      end
   endtask

   task automatic test_parity();
      start_frame(8'h07);
      capture(1, 1'b1, -1, 8'h00, 1'b0, 3000);
      checks++;
      if (line_a[1][152] !== 1'b1 || line_a[1][144] !== 1'b1 || line_a[1][159] !== 1'b1) begin
         failures++;
         $display("FAIL parity_even: bit=%b required=1", line_a[1][152]);
      end
      checks++;
      if (line_a[2][152] !== 1'b0 || line_a[2][144] !== 1'b0 || line_a[2][159] !== 1'b0) begin
         failures++;
         $display("FAIL parity_odd: bit=%b required=0", line_a[2][152]);
      end
      checks++;
      if (ticks_n[1] != 176 || ticks_n[2] != 176 || done_at[1] != 176 || done_at[2] != 176) begin
         failures++;
         $display("FAIL parity_len: ticks=%0d/%0d done_at=%0d/%0d required 176",
                  ticks_n[1], ticks_n[2], done_at[1], done_at[2]);
      end
   endtask

   task automatic test_random_frames();
      int mism;
      logic [7:0] d;
      for (int f = 0; f < 4; f++) begin
         d = 8'($urandom);
         start_frame(d);
         build_model(d);
         capture(1, 1'b1, -1, 8'h00, 1'b0, 3000);
         for (int i = 0; i < NDUT; i++) begin
            mism = 0;
            for (int k = 0; k < exp_len[i]; k++) if (line_a[i][k] !== exp_a[i][k]) mism++;
            checks++;
            if (timed_out || mism != 0 || ticks_n[i] != exp_len[i] || done_cnt[i] != 1 || done_at[i] != exp_len[i]) begin
               failures++;
               $display("FAIL random_frame data=%h dut%0d: bad=%0d ticks=%0d done=%0d required 0/%0d/1",
                        d, i, mism, ticks_n[i], done_cnt[i], exp_len[i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int mism;
      start_frame(8'h0F);
      build_model(8'h0F);
      capture(1, 1'b0, 40, 8'hF0, 1'b1, 2000);
      mism = 0;
      for (int k = 0; k < exp_len[0]; k++) if (line_a[0][k] !== exp_a[0][k]) mism++;
      checks++;
      if (timed_out || mism != 0 || ticks_n[0] != 160 || done_cnt[0] != 1) begin
         failures++;
         $display("FAIL busy_ignore: bad=%0d ticks=%0d done=%0d required 0/160/1", mism, ticks_n[0], done_cnt[0]);
      end
      checks++;
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b1) begin
         failures++;
         $display("FAIL done_cycle: tx=%b busy=%b done=%b required 1/0/1", tx_w[0], busy_w[0], done_w[0]);
      end
      tx_data  = 8'hF0;
      tx_start = 1'b1;
      @(posedge clk); #1;
      tx_start = 1'b0;
      checks++;
      if (tx_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
         failures++;
         $display("FAIL b2b_accept: tx=%b busy=%b required 0/1", tx_w[0], busy_w[0]);
      end
      build_model(8'hF0);
      capture(1, 1'b0, -1, 8'h00, 1'b0, 2000);
      mism = 0;
      for (int k = 0; k < exp_len[0]; k++) if (line_a[0][k] !== exp_a[0][k]) mism++;
      checks++;
      if (timed_out || mism != 0 || ticks_n[0] != 160 || done_cnt[0] != 1 || done_at[0] != 160) begin
         failures++;
         $display("FAIL b2b_frame: bad=%0d ticks=%0d done=%0d required 0/160/1", mism, ticks_n[0], done_cnt[0]);
      end
   endtask

   task automatic test_start_on_last_tick();
      start_frame(8'h3C);
      capture(1, 1'b0, 159, 8'hC3, 1'b0, 2000);
      checks++;
      if (timed_out || ticks_n[0] != 160 || done_cnt[0] != 1 || busy_cyc[0] != 160 || busy_w !== 4'h0) begin
         failures++;
         $display("FAIL last_tick_start: ticks=%0d done=%0d busy_cyc=%0d busy=%b required 160/1/160/0000",
                  ticks_n[0], done_cnt[0], busy_cyc[0], busy_w);
      end
   endtask

   task automatic test_mid_reset();
      int bad;
      int mism;
      start_frame(8'h55);
      repeat (70) begin
         s_tick = 1'b1;
         @(posedge clk); #1;
      end
      checks++;
      if (tx_w[0] !== 1'b0 || busy_w !== 4'hF) begin
         failures++;
         $display("FAIL mid_frame_state: tx=%b busy=%b required tx0=0 busy=1111", tx_w[0], busy_w);
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      checks++;
      if (tx_w !== 4'hF || busy_w !== 4'h0 || done_w !== 4'h0) begin
         failures++;
         $display("FAIL mid_reset: tx=%b busy=%b done=%b required 1111/0000/0000", tx_w, busy_w, done_w);
      end
      bad = 0;
      repeat (200) begin
         s_tick = 1'b1;
         @(posedge clk); #1;
         if (tx_w !== 4'hF || busy_w !== 4'h0 || done_w !== 4'h0) bad++;
      end
      s_tick = 1'b0;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL post_reset_quiet: bad_cycles=%0d required=0", bad);
      end
      start_frame(8'h81);
      build_model(8'h81);
      capture(1, 1'b1, -1, 8'h00, 1'b0, 3000);
      for (int i = 0; i < NDUT; i++) begin
         mism = 0;
         for (int k = 0; k < exp_len[i]; k++) if (line_a[i][k] !== exp_a[i][k]) mism++;
         checks++;
         if (timed_out || mism != 0 || ticks_n[i] != exp_len[i] || done_cnt[i] != 1) begin
            failures++;
            $display("FAIL after_reset_frame dut%0d: bad=%0d ticks=%0d done=%0d required 0/%0d/1",
                     i, mism, ticks_n[i], done_cnt[i], exp_len[i]);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_8n1();
      test_tick_pacing();
      test_parity();
      test_random_frames();
      test_back_to_back();
      test_start_on_last_tick();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
